// File: rtl/hidden_dense_seq_pkg.sv
// Shared types and default coefficients for the sequential dense hidden layer.
// Q4.12 sample type, accumulator sizing, FSM state enum, default weights/biases.
package hidden_pkg;

    typedef logic signed [15:0] q412_t;

    localparam int unsigned FRAC_BITS = 12;
    localparam int unsigned ACC_W     = 40;

    localparam q412_t HID_W [0:15][0:7] = '{16{'{8{16'sh0100}}}};
    localparam q412_t HID_B [0:15]      = '{16{16'sh0000}};

    typedef enum logic [1:0] {
        COLLECT,
        COMPUTE,
        EMIT
    } state_t;

endpackage

// File: rtl/hidden_dense_seq_requant.sv
// q412_requant: rescales a MAC accumulator to Q4.12, adds the bias and saturates.
// Clamps negatives to zero when HIDDEN_DENSE_RELU_EN is defined.
module q412_requant
    import hidden_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    input  q412_t                   bias,
    output q412_t                   res
);

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] biased;
    logic                    pos_ovf;
    logic                    neg_ovf;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        biased  = shifted + {{(ACC_W-16){bias[15]}}, bias};
        // Representable in 16 bits only when every bit above bit 15 copies the sign.
        pos_ovf = !biased[ACC_W-1] && (|biased[ACC_W-2:15]);
        neg_ovf =  biased[ACC_W-1] && !(&biased[ACC_W-2:15]);
        if (pos_ovf) begin
            res = 16'sh7FFF;
        end else if (neg_ovf) begin
            res = 16'sh8000;
        end else begin
            res = biased[15:0];
        end
`ifdef HIDDEN_DENSE_RELU_EN
        if (res[15]) begin
            res = '0;
        end
`endif
    end

endmodule

// File: rtl/hidden_dense_seq.sv
// hidden_dense_seq: time-multiplexed fully-connected layer, one shared MAC, parallel Q4.12 outputs.
// Optional ReLU activation selected by the HIDDEN_DENSE_RELU_EN macro (in q412_requant).
module hidden_dense_seq
    import hidden_pkg::*;
#(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned N_OUT = 16,
    parameter q412_t W [0:N_OUT-1][0:N_IN-1] = HID_W,
    parameter q412_t B [0:N_OUT-1]           = HID_B
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  q412_t in_data,
    output q412_t out_data [0:N_OUT-1],
    output logic  out_valid
);

    localparam int unsigned XW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned IW = $clog2(N_IN + 1);
    localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                  state;
    state_t                  state_n;
    logic [XW-1:0]           k;
    logic [IW-1:0]           i;
    logic [JW-1:0]           j;
    logic [XW-1:0]           xi;
    q412_t                   xbuf [0:N_IN-1];
    q412_t                   res  [0:N_OUT-1];
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      xa;
    logic signed [31:0]      wa;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    q412_t                   fin;
    logic                    accept;
    logic                    last_beat;
    logic                    fin_cyc;
    logic                    last_neuron;

    always_comb begin
        in_ready    = (state == COLLECT);
        accept      = in_valid && in_ready;
        last_beat   = accept && (k == XW'(N_IN - 1));
        fin_cyc     = (state == COMPUTE) && (i == IW'(N_IN));
        last_neuron = (j == JW'(N_OUT - 1));
        // i reaches N_IN only on the finalise cycle, where the product is unused.
        xi          = i[XW-1:0];
        xa          = {{16{xbuf[xi][15]}}, xbuf[xi]};
        wa          = {{16{W[j][xi][15]}}, W[j][xi]};
        prod        = xa * wa;
        prod_ext    = {{(ACC_W-32){prod[31]}}, prod};
    end

    always_comb begin
        state_n = state;
        case (state)
            COLLECT: if (last_beat) state_n = COMPUTE;
            COMPUTE: if (fin_cyc && last_neuron) state_n = EMIT;
            EMIT:    state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    q412_requant u_requant (
        .acc  (acc),
        .bias (B[j]),
        .res  (fin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k         <= '0;
            i         <= '0;
            j         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            xbuf      <= '{default: '0};
            res       <= '{default: '0};
            out_data  <= '{default: '0};
        end else begin
            out_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        xbuf[k] <= in_data;
                        k       <= last_beat ? '0 : k + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (fin_cyc) begin
                        res[j] <= fin;
                        acc    <= '0;
                        i      <= '0;
                        j      <= last_neuron ? '0 : j + 1'b1;
                    end else begin
                        acc <= acc + prod_ext;
                        i   <= i + 1'b1;
                    end
                end
                EMIT: begin
                    out_data  <= res;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_dense_seq.sv
// Scoreboard bench for hidden_dense_seq: drivers push expected vectors, a negedge monitor pops on out_valid.
// Expected negative outputs follow HIDDEN_DENSE_RELU_EN when it is defined.
module tb_hidden_dense_seq;
    import hidden_pkg::*;

    typedef logic [15:0][15:0] vec_t;
    typedef logic [7:0][15:0]  xvec_t;

    // Rows 0-7: uniform 256 with bias 16*j; rows 8-11: 32767; rows 12-14: -4096; row 15: mixed.
    localparam q412_t TW [0:15][0:7] = '{
        '{8{16'sd256}}, '{8{16'sd256}}, '{8{16'sd256}}, '{8{16'sd256}},
        '{8{16'sd256}}, '{8{16'sd256}}, '{8{16'sd256}}, '{8{16'sd256}},
        '{8{16'sd32767}}, '{8{16'sd32767}}, '{8{16'sd32767}}, '{8{16'sd32767}},
        '{8{-16'sd4096}}, '{8{-16'sd4096}}, '{8{-16'sd4096}},
        '{16'sd4096, -16'sd4096, 16'sd2048, 16'sd0, 16'sd8192, -16'sd2048, 16'sd1024, 16'sd512}
    };
    localparam q412_t TB [0:15] = '{
        16'sd0, 16'sd16, 16'sd32, 16'sd48, 16'sd64, 16'sd80, 16'sd96, 16'sd112,
        16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd100
    };

    logic  clk = 1'b0;
    logic  reset;
    logic  in_valid;
    logic  in_ready;
    q412_t in_data;
    q412_t out_data [0:15];
    logic  out_valid;

    int          total = 0;
    int          bad   = 0;
    int          emits = 0;
    int unsigned cyc   = 0;
    vec_t        exp_q [$];
    int unsigned lat_q [$];
    vec_t        held  = '0;
    vec_t        mon_e;
    int unsigned mon_l;

    hidden_dense_seq #(
        .N_IN  (8),
        .N_OUT (16),
        .W     (TW),
        .B     (TB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int relu(input int v);
`ifdef HIDDEN_DENSE_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic vec_t grp(input int a, input int b, input int c, input int d);
        vec_t e;
        for (int n = 0; n < 8; n++)   e[n] = 16'(a + 16 * n);
        for (int n = 8; n < 12; n++)  e[n] = 16'(b);
        for (int n = 12; n < 15; n++) e[n] = 16'(relu(c));
        e[15] = 16'(relu(d));
        return e;
    endfunction

    function automatic vec_t model(input xvec_t x);
        vec_t   e;
        longint acc;
        longint v;
        for (int r = 0; r < 16; r++) begin
            acc = 0;
            for (int c = 0; c < 8; c++) acc += longint'($signed(x[c])) * longint'(TW[r][c]);
            v = (acc >>> 12) + longint'(TB[r]);
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            e[r] = 16'(relu(int'(v)));
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_l = lat_q.pop_front();
                for (int n = 0; n < 16; n++)
                    chk($sformatf("out_data[%0d]", n), int'(out_data[n]), int'($signed(mon_e[n])));
                chk("latency", int'(cyc - mon_l), 145);
                held = mon_e;
                emits++;
            end
        end
    end

    task automatic send(input xvec_t x, input bit gaps, input bit push, input vec_t e);
        int unsigned n = 0;
        int unsigned t = 0;
        while (n < 8) begin
            @(negedge clk);
            if (gaps && ((t % 4 == 1) || (t % 4 == 2))) begin
                in_valid = 1'b0;
                in_data  = 16'sh5A5A;
            end else begin
                in_valid = 1'b1;
                in_data  = x[n];
            end
            t++;
            if (in_valid && in_ready) n++;
            if (t > 200) begin
                chk("send_timeout", int'(n), 8);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            exp_q.push_back(e);
            lat_q.push_back(cyc);
        end
    endtask

    task automatic during_compute(input int unsigned cycles, input bit extra);
        int rdy_hi = 0;
        int diff   = 0;
        for (int unsigned c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (extra && c < 5) begin
                in_valid = 1'b1;
                in_data  = 16'sh7FFF;
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready) rdy_hi++;
            if (c == 70) begin
                for (int n = 0; n < 16; n++)
                    if (out_data[n] != $signed(held[n])) diff++;
                chk("out_data_hold", diff, 0);
            end
        end
        in_valid = 1'b0;
        chk("in_ready_low_in_compute", rdy_hi, 0);
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("emit_timeout", exp_q.size(), 0);
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        int nz = 0;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready_during"}, int'(in_ready), 1);
        reset = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 16; n++) if (out_data[n] != 16'sd0) nz++;
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_data_zero"}, nz, 0);
        held = '0;
    endtask

    initial begin
        xvec_t x4096;
        xvec_t x32767;
        xvec_t x2048;
        xvec_t xmix;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        for (int n = 0; n < 8; n++) begin
            x4096[n]  = 16'd4096;
            x32767[n] = 16'd32767;
            x2048[n]  = 16'd2048;
        end
        xmix = {16'd300, 16'd0, 16'sh8000, 16'sh7FFF, 16'hFFFF, 16'd1000, 16'hE000, 16'd4096};

        repeat (2) @(negedge clk);
        do_reset("rst_init");

        send(x4096, 1'b0, 1'b1, grp(2048, 32767, -32768, 9628));
        during_compute(144, 1'b0);
        wait_drain();

        send(x32767, 1'b0, 1'b1, grp(16383, 32767, -32768, 32767));
        during_compute(144, 1'b0);
        wait_drain();

        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'sd12345;
        end
        @(negedge clk);
        in_valid = 1'b0;
        do_reset("rst_collect");

        send(xmix, 1'b1, 1'b1, model(xmix));
        during_compute(144, 1'b1);
        wait_drain();

        send(x4096, 1'b0, 1'b0, '0);
        during_compute(50, 1'b0);
        do_reset("rst_compute");

        send(x2048, 1'b0, 1'b1, grp(1024, 32767, -16384, 4764));
        during_compute(144, 1'b0);
        wait_drain();

        repeat (20) @(negedge clk);
        chk("emit_count", emits, 4);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
